// File: rtl/sqrt_inverse_square.sv
// Purpose : squares an unsigned Q10.6 magnitude back to a rounded, saturated integer power.
// Latency : 18 enabled cycles per result (accept + 16 shift-add steps + round); ce low stretches it.
// Backpr. : din_ready is high only while idle; din_valid while busy is ignored, never queued.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   ce                  clock enable; all state holds while low (dout_valid still self-clears)
//   din, din_valid      Q10.6 magnitude and its qualifier, taken when din_ready & ce
//   din_ready           high in IDLE only
//   dout, dout_valid    rounded integer square, one-cycle pulse on each new result
//   dout_ovf            result was clipped to all ones; held until the next result
module sqrt_inverse_square #(
    parameter int IN_WIDTH  = 16,
    parameter int IN_FRAC   = 6,
    parameter int OUT_WIDTH = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic                 dout_ovf
);

    localparam int ACC_W = 2 * IN_WIDTH;
    localparam int CNT_W = $clog2(IN_WIDTH);
    localparam int SHIFT = 2 * IN_FRAC;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MUL   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);
    // One half LSB of the integer result, expressed in the Q20.12 accumulator scale.
    localparam logic [ACC_W:0]   RND_HALF = (ACC_W + 1)'(1) << (SHIFT - 1);

    logic [1:0]           state;
    logic [IN_WIDTH-1:0]  opnd;      // serves as both multiplicand and multiplier
    logic [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]     cnt;

    logic [ACC_W-1:0]     pp;
    logic [ACC_W:0]       acc_rnd;
    logic [ACC_W:0]       r_full;
    logic                 sat;

    always_comb begin
        pp      = ACC_W'(opnd) << cnt;
        // One spare bit so adding the half LSB can never wrap.
        acc_rnd = {1'b0, acc} + RND_HALF;
        r_full  = acc_rnd >> SHIFT;
        sat     = |r_full[ACC_W:OUT_WIDTH];
    end

    assign din_ready = (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            opnd       <= '0;
            acc        <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_ovf   <= 1'b0;
        end else begin
            // Pulse clears every clock, even with ce low, so it is never stretched.
            dout_valid <= 1'b0;
            if (ce) begin
                case (state)
                    S_IDLE: begin
                        if (din_valid) begin
                            opnd  <= din;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= S_MUL;
                        end
                    end
                    S_MUL: begin
                        if (opnd[cnt]) begin
                            acc <= acc + pp;
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            state <= S_ROUND;
                        end
                    end
                    S_ROUND: begin
                        dout_valid <= 1'b1;
                        dout_ovf   <= sat;
                        if (sat) begin
                            dout <= '1;
                        end else begin
                            dout <= r_full[OUT_WIDTH-1:0];
                        end
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
